fast_scan_controller: RTL and testbench
=======================================

// Module: fast_scan_controller
// PURPOSE
//  Raster-scan sequencer for the FAST front end. Walks every valid centre pixel of a
//  frame (skipping BORDER px on each edge) and pulses buffer_loader once per centre.
//  Waits for loader done, then offers the window coordinates downstream to the
//  corner classifier over a valid/ready handshake. Sits between the frame-level
//  control (frame_start) and buffer_loader; owns the curr_x/curr_y nets.
// PARAMETERS
//  IMG_W     320  frame width in pixels, 2*BORDER+1 .. 512
//  IMG_H     240  frame height in pixels, 2*BORDER+1 .. 512
//  BORDER    3    edge margin; equals the Bresenham-16 circle radius
//  TIMEOUT   64   max cycles in WAIT_LOAD before the frame is aborted with error
// PORTS
//  clk          in   1   system clock, rising edge
//  n_rst        in   1   asynchronous active-low reset
//  frame_start  in   1   1-cycle request to scan a frame; ignored while busy=1
//  abort        in   1   synchronous abort of the current frame
//  loader_start out  1   1-cycle start pulse to buffer_loader
//  loader_done  in   1   buffer_loader finished; only sampled in WAIT_LOAD
//  curr_x       out  9   centre x driven to buffer_loader; stable LAUNCH..ADVANCE
//  curr_y       out  9   centre y driven to buffer_loader; stable LAUNCH..ADVANCE
//  win_valid    out  1   window for (win_x, win_y) ready in loader outputs
//  win_ready    in   1   downstream accepts the window
//  win_x        out  9   x of offered window (== curr_x while win_valid)
//  win_y        out  9   y of offered window (== curr_y while win_valid)
//  busy         out  1   high from first LAUNCH until return to IDLE
//  frame_done   out  1   1-cycle pulse after last window accepted or on timeout
//  timeout_err  out  1   sticky; set on loader timeout, cleared by next frame_start
//  win_count    out  18  windows accepted in current/last frame
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; curr_x=curr_y=0; counters 0.
//  FSM (one-hot or enum): IDLE, LAUNCH, WAIT_LOAD, EMIT, ADVANCE, FINISH.
//  IDLE: frame_start=1 -> curr_x=curr_y=BORDER, win_count=0, timeout_err=0, -> LAUNCH.
//  LAUNCH: loader_start=1 for exactly this cycle; timer=0; -> WAIT_LOAD.
//  WAIT_LOAD: loader_done=1 -> EMIT. Else timer++; timer==TIMEOUT-1 ->
//    timeout_err=1, -> FINISH. loader_done in the LAUNCH cycle is ignored.
//  EMIT: win_valid=1, win_x/win_y held; must not drop or change until win_ready.
//    win_valid&win_ready -> win_count++, -> ADVANCE. win_ready outside EMIT ignored.
//  ADVANCE: if curr_x==IMG_W-1-BORDER: curr_x=BORDER, curr_y++ else curr_x++.
//    Last centre (x==IMG_W-1-BORDER, y==IMG_H-1-BORDER) -> FINISH (coords not
//    advanced), else -> LAUNCH.
//  FINISH: frame_done=1 one cycle, busy=0 from next cycle, -> IDLE.
//  Per-window cost with win_ready=1 and loader latency L: L+3 cycles.
//  abort=1 in any non-IDLE state: -> IDLE next cycle, win_valid/loader_start drop,
//    no frame_done, win_count/timeout_err retained. abort has priority over every
//    other transition; abort in IDLE has no effect.
//  frame_start while busy: ignored (no restart, no queueing).
//  Async reset mid-frame: immediate return to reset values; next frame needs frame_start.
//  Coordinates: 9-bit unsigned, never wrap; the ADVANCE compare drives all wrap-around.
// STRUCTURE
//  Package fast_pkg: COORD_W=9, COUNT_W=18, BORDER default, scan_state_t enum.
//  Sub-module scan_coord_gen: holds curr_x/curr_y, inputs init/step, outputs last_x,
//    last_frame; the FSM and the timeout timer stay in fast_scan_controller.
// TESTING (bench instantiates controller + buffer_loader or a done-after-N model)
//  IMG_W=IMG_H=8, BORDER=3, win_ready=1 -> windows (3,3),(4,3),(3,4),(4,4) in order;
//    frame_done once; win_count=4; busy falls the cycle after frame_done.
//  Backpressure: hold win_ready=0 for 10 cycles in EMIT -> win_valid/win_x/win_y
//    stable throughout; no loader_start until the handshake completes.
//  Loader model never asserts done, TIMEOUT=64 -> timeout_err=1 and frame_done 64
//    cycles after loader_start; next frame_start clears timeout_err.
//  abort during second WAIT_LOAD -> IDLE next cycle, no frame_done, win_count=1.
//  frame_start pulsed mid-frame -> no effect on coords; n_rst low mid-EMIT -> all
//    outputs 0 immediately; new frame_start rescans from (3,3).
//  Default 320x240 with real buffer_loader -> win_count=314*234=73476 at frame_done.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared widths, scan FSM state encoding and sizing helper for the FAST scan front end.
package fast_pkg;

  localparam int unsigned COORD_W        = 9;
  localparam int unsigned COUNT_W        = 18;
  localparam int unsigned BORDER_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_LOAD,
    ST_EMIT,
    ST_ADVANCE,
    ST_FINISH
  } scan_state_t;

  // Width of a counter that must reach the value 'limit' without overflowing.
  function automatic int unsigned count_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/scan_coord_gen.sv
// Centre-pixel coordinate register for the raster walk; reports row end and frame end.
module scan_coord_gen
  import fast_pkg::*;
#(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned BORDER = BORDER_DEFAULT
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               init,
  input  logic               step,
  output logic [COORD_W-1:0] curr_x,
  output logic [COORD_W-1:0] curr_y,
  output logic               last_x,
  output logic               last_frame
);

  localparam logic [COORD_W-1:0] FIRST  = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1 - BORDER);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1 - BORDER);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // Row-major advance; wrap to the first column happens only at the row end compare.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (init) begin
      x_d = FIRST;
      y_d = FIRST;
    end else if (step) begin
      if (last_x) begin
        x_d = FIRST;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign last_x     = (x_q == X_LAST);
  assign last_frame = last_x && (y_q == Y_LAST);
  assign curr_x     = x_q;
  assign curr_y     = y_q;

endmodule

// File: rtl/fast_scan_controller.sv
// Raster-scan sequencer: launches buffer_loader per centre pixel, then offers the window downstream.
module fast_scan_controller
  import fast_pkg::*;
#(
  parameter int unsigned IMG_W   = 320,
  parameter int unsigned IMG_H   = 240,
  parameter int unsigned BORDER  = BORDER_DEFAULT,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               frame_start,
  input  logic               abort,
  output logic               loader_start,
  input  logic               loader_done,
  output logic [COORD_W-1:0] curr_x,
  output logic [COORD_W-1:0] curr_y,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] win_count
);

  localparam int unsigned TIMER_W = count_width(TIMEOUT);

  scan_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0] win_count_q, win_count_d;
  logic               timeout_err_q, timeout_err_d;
  logic               loader_start_q, loader_start_d;
  logic               win_valid_q, win_valid_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               coord_init;
  logic               coord_step;
  logic               last_x;
  logic               last_frame;

  scan_coord_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .BORDER (BORDER)
  ) u_coord (
    .clk        (clk),
    .n_rst      (n_rst),
    .init       (coord_init),
    .step       (coord_step),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .last_x     (last_x),
    .last_frame (last_frame)
  );

  // Next state; abort outranks every other transition once a frame is running.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    win_count_d   = win_count_q;
    timeout_err_d = timeout_err_q;
    coord_init    = 1'b0;
    coord_step    = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            coord_init    = 1'b1;
            win_count_d   = '0;
            timeout_err_d = 1'b0;
            state_d       = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          timer_d = '0;
          state_d = ST_WAIT_LOAD;
        end
        ST_WAIT_LOAD: begin
          if (loader_done) begin
            state_d = ST_EMIT;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_d == TIMER_W'(TIMEOUT - 1)) begin
              timeout_err_d = 1'b1;
              state_d       = ST_FINISH;
            end
          end
        end
        ST_EMIT: begin
          if (win_ready) begin
            win_count_d = win_count_q + COUNT_W'(1);
            state_d     = ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (last_frame) begin
            state_d = ST_FINISH;
          end else begin
            coord_step = 1'b1;
            state_d    = ST_LAUNCH;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered copies of the decoded next state.
  always_comb begin
    loader_start_d = (state_d == ST_LAUNCH);
    win_valid_d    = (state_d == ST_EMIT);
    busy_d         = (state_d != ST_IDLE);
    frame_done_d   = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      win_count_q    <= '0;
      timeout_err_q  <= 1'b0;
      loader_start_q <= 1'b0;
      win_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      win_count_q    <= win_count_d;
      timeout_err_q  <= timeout_err_d;
      loader_start_q <= loader_start_d;
      win_valid_q    <= win_valid_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign loader_start = loader_start_q;
  assign win_valid    = win_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;
  assign win_count    = win_count_q;
  assign win_x        = curr_x;
  assign win_y        = curr_y;

endmodule

// File: tb/tb_fast_scan_controller.sv
// Scoreboard bench for fast_scan_controller on an 8x8 frame with a done-after-N loader model.
module tb_fast_scan_controller;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned B  = 3;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        frame_start;
  logic        abort;
  logic        loader_start;
  logic        loader_done;
  logic [8:0]  curr_x, curr_y, win_x, win_y;
  logic        win_valid;
  logic        win_ready;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic [17:0] win_count;

  always #5 clk = ~clk;

  fast_scan_controller #(
    .IMG_W   (W),
    .IMG_H   (H),
    .BORDER  (B),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .frame_start  (frame_start),
    .abort        (abort),
    .loader_start (loader_start),
    .loader_done  (loader_done),
    .curr_x       (curr_x),
    .curr_y       (curr_y),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_x        (win_x),
    .win_y        (win_y),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err),
    .win_count    (win_count)
  );

  typedef struct {
    int x;
    int y;
  } win_t;

  win_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lat = 2;
  bit   loader_dead = 0;
  bit   glitch = 0;
  int   ready_mode = 0;
  int   ld_cnt = 0;
  int   done_pulses = 0;
  int   hs_count = 0;
  int   launch_cnt = 0;
  int   first_start_cyc = 0;
  int   done_cyc = 0;
  bit   first_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_loader_start"}, 32'(loader_start), 0);
    chk({tag, "_win_valid"}, 32'(win_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_curr_x"}, 32'(curr_x), 0);
    chk({tag, "_curr_y"}, 32'(curr_y), 0);
    chk({tag, "_win_x"}, 32'(win_x), 0);
    chk({tag, "_win_y"}, 32'(win_y), 0);
    chk({tag, "_win_count"}, 32'(win_count), 0);
  endtask

  // Reference model: every centre pixel, row-major, borders excluded.
  task automatic start_frame();
    exp_q.delete();
    for (int yi = int'(B); yi <= int'(H - 1 - B); yi++)
      for (int xi = int'(B); xi <= int'(W - 1 - B); xi++)
        exp_q.push_back('{x: xi, y: yi});
    hs_count   = 0;
    first_seen = 0;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0   = done_pulses;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (done_pulses != d0) seen = 1;
    end
    chk("frame_done_seen", 32'(seen), 1);
    tick(2);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (win_valid) seen = 1;
    end
    chk("win_valid_seen", 32'(seen), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Loader model: done one cycle, lat cycles after start; optional stray done during LAUNCH.
  initial begin
    loader_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      loader_done = 1'b0;
      if (!busy) begin
        ld_cnt = 0;
      end else if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0) loader_done = 1'b1;
      end else if (loader_start && !loader_dead) begin
        ld_cnt = lat;
        loader_done = glitch;
      end
    end
  end

  initial begin
    win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = ($urandom_range(0, 2) != 0);
        default: win_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops on handshake, plus hold/launch/frame_done protocol checks.
  initial begin
    bit          pv_valid, pv_ready, pv_abort, pv_done;
    logic [8:0]  pv_x, pv_y;
    win_t        e;
    pv_valid = 0; pv_ready = 0; pv_abort = 0; pv_done = 0; pv_x = '0; pv_y = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pv_valid = 0;
        pv_done  = 0;
      end else begin
        if (win_valid && win_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_window", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("win_x", 32'(win_x), e.x);
            chk("win_y", 32'(win_y), e.y);
            hs_count++;
          end
        end
        if (pv_valid && !pv_ready && !pv_abort) begin
          chk("hold_valid", 32'(win_valid), 1);
          chk("hold_x", 32'(win_x), 32'(pv_x));
          chk("hold_y", 32'(win_y), 32'(pv_y));
        end
        if (loader_start) begin
          chk("launch_while_valid", 32'(win_valid), 0);
          launch_cnt++;
          if (!first_seen) first_start_cyc = cyc;
          first_seen = 1;
        end
        if (pv_done) chk("busy_after_done", 32'(busy), 0);
        if (frame_done) begin
          done_pulses++;
          done_cyc = cyc;
          chk("win_count_at_done", 32'(win_count), hs_count);
        end
        pv_valid = win_valid;
        pv_ready = win_ready;
        pv_abort = abort;
        pv_done  = frame_done;
        pv_x     = win_x;
        pv_y     = win_y;
      end
    end
  end

  initial begin
    int d0, lc;
    n_rst = 1'b0;
    frame_start = 1'b0;
    abort = 1'b0;
    tick(3);
    check_all_zero("reset");
    n_rst = 1'b1;
    tick(2);

    // Nominal frame, fixed latency, always ready.
    lat = 2; ready_mode = 0; d0 = done_pulses;
    start_frame();
    wait_done(200);
    chk("nominal_queue_empty", 32'(exp_q.size()), 0);
    chk("nominal_done_once", 32'(done_pulses - d0), 1);
    chk("nominal_win_count", 32'(win_count), 4);
    chk("nominal_frame_cycles", 32'(done_cyc - first_start_cyc), 4 * (lat + 3));
    chk("nominal_timeout_err", 32'(timeout_err), 0);

    // Backpressure in EMIT: window must hold and no new launch.
    ready_mode = 2;
    start_frame();
    wait_valid(100);
    lc = launch_cnt;
    tick(10);
    chk("bp_valid_held", 32'(win_valid), 1);
    chk("bp_no_launch", 32'(launch_cnt), 32'(lc));
    ready_mode = 0;
    wait_done(200);
    chk("bp_win_count", 32'(win_count), 4);

    // Loader never answers: timeout.
    loader_dead = 1; d0 = done_pulses;
    start_frame();
    wait_done(200);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_latency", 32'(done_cyc - first_start_cyc), TO);
    chk("to_done_once", 32'(done_pulses - d0), 1);
    chk("to_win_count", 32'(win_count), 0);
    loader_dead = 0;
    start_frame();
    chk("to_err_cleared", 32'(timeout_err), 0);
    wait_done(200);
    chk("after_to_win_count", 32'(win_count), 4);

    // Abort during the second WAIT_LOAD.
    lat = 5; d0 = done_pulses; lc = launch_cnt;
    start_frame();
    for (int i = 0; i < 100 && launch_cnt < lc + 2; i++) tick(1);
    chk("abort_reached_second_launch", 32'(launch_cnt - lc), 2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(win_valid), 0);
    chk("abort_loader_start", 32'(loader_start), 0);
    exp_q.delete();
    tick(20);
    chk("abort_no_done", 32'(done_pulses - d0), 0);
    chk("abort_win_count", 32'(win_count), 1);
    abort = 1'b1;
    tick(2);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_win_count", 32'(win_count), 1);

    // frame_start while busy is ignored.
    lat = 3; ready_mode = 1; d0 = done_pulses;
    start_frame();
    tick(7);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_done(300);
    chk("midstart_done_once", 32'(done_pulses - d0), 1);
    chk("midstart_win_count", 32'(win_count), 4);
    chk("midstart_queue_empty", 32'(exp_q.size()), 0);

    // Async reset in EMIT, then a clean rescan.
    ready_mode = 2;
    start_frame();
    wait_valid(100);
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    tick(2);
    n_rst = 1'b1;
    tick(2);
    ready_mode = 0;
    start_frame();
    wait_done(200);
    chk("rescan_win_count", 32'(win_count), 4);
    chk("rescan_queue_empty", 32'(exp_q.size()), 0);

    // Randomised latency, stray done in LAUNCH, random backpressure.
    for (int f = 0; f < 6; f++) begin
      lat = int'($urandom_range(1, 6));
      glitch = 1'($urandom_range(0, 1));
      ready_mode = 1;
      start_frame();
      wait_done(400);
      chk("rand_win_count", 32'(win_count), 4);
      chk("rand_queue_empty", 32'(exp_q.size()), 0);
      chk("rand_timeout_err", 32'(timeout_err), 0);
    end
    glitch = 0;

    tick(5);
    chk("final_idle", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
